// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Each of STAGES stages adds one SEG-bit segment with GROUP-bit lookahead.
// Higher operand segments are carried forward (skew) and finished result
// segments are accumulated (de-skew), so one transaction's whole result
// leaves the last stage together. Latency STAGES, one result per cycle.
//
// Optional feature: define CLA_OVERFLOW_EN to add the o_overflow port.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_valid / o_ready     input handshake
//   i_add1, i_add2        operands A, B
//   i_carry               carry-in (add mode only)
//   i_sub                 1: A - B, 0: A + B + i_carry
//   o_valid / i_ready     output handshake
//   o_result, o_carry     sum/difference and MSB carry-out (1 = no borrow)
//   o_overflow            signed overflow (CLA_OVERFLOW_EN only)
module pipelined_cla_adder #(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned STAGES = 3,
    parameter int unsigned GROUP  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
`ifdef CLA_OVERFLOW_EN
    output logic             o_overflow,
`endif
    output logic             o_carry
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned NGRP = SEG / GROUP;

    // One segment: bit G/P, group G/P, lookahead carries between groups,
    // then per-bit carries inside each group. Returns {carry_out, sum}.
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           cin);
        logic [SEG-1:0]  g;
        logic [SEG-1:0]  p;
        logic [SEG-1:0]  s;
        logic [NGRP:0]   gc;
        logic            gg;
        logic            gp;
        logic            c;
        g     = a & b;
        p     = a | b;
        s     = '0;
        gc    = '0;
        gc[0] = cin;
        for (int j = 0; j < int'(NGRP); j++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < int'(GROUP); i++) begin
                gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
                gp = gp & p[j*GROUP+i];
            end
            gc[j+1] = gg | (gp & gc[j]);
        end
        for (int j = 0; j < int'(NGRP); j++) begin
            c = gc[j];
            for (int i = 0; i < int'(GROUP); i++) begin
                s[j*GROUP+i] = a[j*GROUP+i] ^ b[j*GROUP+i] ^ c;
                c = g[j*GROUP+i] | (p[j*GROUP+i] & c);
            end
        end
        return {gc[NGRP], s};
    endfunction

    // Whole pipeline advances together unless the output is blocked.
    logic             w_en;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;

    assign w_en    = !(o_valid && !i_ready);
    assign o_ready = w_en;

    // Subtract as A + ~B + 1; i_carry ignored in subtract mode.
    assign w_b0 = i_sub ? ~i_add2 : i_add2;
    assign w_c0 = i_sub | i_carry;

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        localparam int unsigned LO   = k * SEG;
        localparam int unsigned HI_W = WIDTH - LO;

        logic [HI_W-1:0]   w_a;
        logic [HI_W-1:0]   w_b;
        logic              w_cin;
        logic              w_vin;
        logic [SEG:0]      w_seg;
        logic [LO+SEG-1:0] w_sum;
        logic              r_valid;
        logic              r_c;
        logic [LO+SEG-1:0] r_sum;

        assign w_seg = cla_seg(w_a[SEG-1:0], w_b[SEG-1:0], w_cin);

        if (k == 0) begin : g_first
            assign w_a   = i_add1;
            assign w_b   = w_b0;
            assign w_cin = w_c0;
            assign w_vin = i_valid;
            assign w_sum = w_seg[SEG-1:0];
        end else begin : g_next
            assign w_a   = g_stage[k-1].g_skew.r_a;
            assign w_b   = g_stage[k-1].g_skew.r_b;
            assign w_cin = g_stage[k-1].r_c;
            assign w_vin = g_stage[k-1].r_valid;
            assign w_sum = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
        end

        // Valid, carry and accumulated result segments for this stage.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_valid <= 1'b0;
                r_c     <= 1'b0;
                r_sum   <= '0;
            end else if (w_en) begin
                r_valid <= w_vin;
                r_c     <= w_seg[SEG];
                r_sum   <= w_sum;
            end
        end

        // Operand segments not yet consumed travel with the transaction.
        if (k < int'(STAGES) - 1) begin : g_skew
            logic [HI_W-SEG-1:0] r_a;
            logic [HI_W-SEG-1:0] r_b;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a[HI_W-1:SEG];
                    r_b <= w_b[HI_W-1:SEG];
                end
            end
        end

`ifdef CLA_OVERFLOW_EN
        // Sign bits only exist in the top segment, i.e. the last stage.
        if (k == int'(STAGES) - 1) begin : g_ovf
            logic r_ovf;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_en) begin
                    r_ovf <= (w_a[HI_W-1] == w_b[HI_W-1]) &&
                             (w_seg[SEG-1] != w_a[HI_W-1]);
                end
            end
        end
`endif
    end

    assign o_valid  = g_stage[STAGES-1].r_valid;
    assign o_result = g_stage[STAGES-1].r_sum;
    assign o_carry  = g_stage[STAGES-1].r_c;
`ifdef CLA_OVERFLOW_EN
    assign o_overflow = g_stage[STAGES-1].g_ovf.r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and randomized checks of pipelined_cla_adder (WIDTH=24, STAGES=3).
module tb_pipelined_cla_adder;

    localparam int unsigned W = 24;

    logic         clk;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_add1;
    logic [W-1:0] i_add2;
    logic         i_carry;
    logic         i_sub;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;
    logic         o_carry;
`ifdef CLA_OVERFLOW_EN
    logic         o_overflow;
`endif

    int total;
    int bad;

    pipelined_cla_adder #(.WIDTH(24), .STAGES(3), .GROUP(4)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_add1    (i_add1),
        .i_add2    (i_add2),
        .i_carry   (i_carry),
        .i_sub     (i_sub),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
`ifdef CLA_OVERFLOW_EN
        .o_overflow(o_overflow),
`endif
        .o_carry   (o_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
        i_add1  = a;
        i_add2  = b;
        i_carry = c;
        i_sub   = s;
        i_valid = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] r,
                           input logic c, input logic v);
        chk({tag, ".valid"}, 32'(o_valid), 32'(1'b1));
        chk({tag, ".result"}, 32'(o_result), 32'(r));
        chk({tag, ".carry"}, 32'(o_carry), 32'(c));
`ifdef CLA_OVERFLOW_EN
        chk({tag, ".ovf"}, 32'(o_overflow), 32'(v));
`else
        if (v) begin end
`endif
    endtask

    // Stream vectors: A, B, cin, sub, expected result, carry, overflow
    logic [W-1:0] sa [5];
    logic [W-1:0] sb [5];
    logic         sc [5];
    logic         ss [5];
    logic [W-1:0] er [5];
    logic         ec [5];
    logic         ev [5];

    // Scoreboard for the random phase
    logic [W+1:0] q[$];

    initial begin
        int in_idx;
        int out_idx;
        logic [W+1:0] exp_e;
        logic [W:0]   full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] bb;
        logic         rc;
        logic         rs;
        logic         took;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_add1 = '0;
        i_add2 = '0;
        i_carry = 1'b0;
        i_sub = 1'b0;

        // Reset state
        #13;
        chk("rst.valid", 32'(o_valid), 32'(1'b0));
        chk("rst.result", 32'(o_result), 32'h0);
        chk("rst.carry", 32'(o_carry), 32'(1'b0));
        chk("rst.ready", 32'(o_ready), 32'(1'b1));
`ifdef CLA_OVERFLOW_EN
        chk("rst.ovf", 32'(o_overflow), 32'(1'b0));
`endif
        cyc();
        rst_n = 1'b1;
        cyc();

        // Full-width carry chain, latency exactly 3
        drive(24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
        cyc();
        i_valid = 1'b0;
        chk("lat.c1", 32'(o_valid), 32'(1'b0));
        cyc();
        chk("lat.c2", 32'(o_valid), 32'(1'b0));
        cyc();
        chk_out("carrychain", 24'h000000, 1'b1, 1'b0);
        cyc();
        chk("bubble", 32'(o_valid), 32'(1'b0));

        // Subtract, with i_carry ignored in subtract mode
        drive(24'h000005, 24'h000007, 1'b0, 1'b1);
        cyc();
        drive(24'h000005, 24'h000007, 1'b1, 1'b1);
        cyc();
        i_valid = 1'b0;
        cyc();
        chk_out("sub", 24'hFFFFFE, 1'b0, 1'b0);
        cyc();
        chk_out("sub.cin1", 24'hFFFFFE, 1'b0, 1'b0);
        cyc();

        // Signed overflow on add
        drive(24'h7FFFFF, 24'h000001, 1'b0, 1'b0);
        cyc();
        i_valid = 1'b0;
        cyc();
        cyc();
        chk_out("ovf", 24'h800000, 1'b0, 1'b1);
        cyc();

        // Five back-to-back inputs with a 2-cycle output stall
        sa[0] = 24'h000001; sb[0] = 24'h000002; sc[0] = 0; ss[0] = 0; er[0] = 24'h000003; ec[0] = 0; ev[0] = 0;
        sa[1] = 24'h123456; sb[1] = 24'h654321; sc[1] = 1; ss[1] = 0; er[1] = 24'h777778; ec[1] = 0; ev[1] = 0;
        sa[2] = 24'h800000; sb[2] = 24'h800000; sc[2] = 0; ss[2] = 0; er[2] = 24'h000000; ec[2] = 1; ev[2] = 1;
        sa[3] = 24'h000010; sb[3] = 24'h000010; sc[3] = 0; ss[3] = 1; er[3] = 24'h000000; ec[3] = 1; ev[3] = 0;
        sa[4] = 24'hABCDEF; sb[4] = 24'h111111; sc[4] = 0; ss[4] = 0; er[4] = 24'hBCDF00; ec[4] = 0; ev[4] = 0;
        in_idx  = 0;
        out_idx = 0;
        for (int n = 0; n < 12; n++) begin
            logic exp_v;
            logic exp_rdy;
            i_ready = !(n == 4 || n == 5);
            if (in_idx < 5) drive(sa[in_idx], sb[in_idx], sc[in_idx], ss[in_idx]);
            else i_valid = 1'b0;
            #1;
            exp_v   = (n >= 3 && n <= 9);
            exp_rdy = !(n == 4 || n == 5);
            chk($sformatf("stream.ready[%0d]", n), 32'(o_ready), 32'(exp_rdy));
            if (exp_v) chk_out($sformatf("stream[%0d]", n), er[out_idx], ec[out_idx], ev[out_idx]);
            else chk($sformatf("stream.valid[%0d]", n), 32'(o_valid), 32'(1'b0));
            if (exp_v && i_ready) out_idx++;
            if (exp_rdy && in_idx < 5) in_idx++;
            cyc();
        end
        chk("stream.count", 32'(out_idx), 32'd5);
        i_ready = 1'b1;

        // Reset with three transactions in flight
        drive(24'h000100, 24'h000001, 1'b0, 1'b0);
        cyc();
        drive(24'h000200, 24'h000002, 1'b0, 1'b0);
        cyc();
        drive(24'h000300, 24'h000003, 1'b0, 1'b0);
        cyc();
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", 32'(o_valid), 32'(1'b0));
        chk("midrst.result", 32'(o_result), 32'h0);
        chk("midrst.ready", 32'(o_ready), 32'(1'b1));
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cyc();
            chk($sformatf("postrst.empty[%0d]", n), 32'(o_valid), 32'(1'b0));
        end
        drive(24'h00000A, 24'h000014, 1'b0, 1'b0);
        cyc();
        i_valid = 1'b0;
        chk("postrst.c1", 32'(o_valid), 32'(1'b0));
        cyc();
        chk("postrst.c2", 32'(o_valid), 32'(1'b0));
        cyc();
        chk_out("postrst", 24'h00001E, 1'b0, 1'b0);
        cyc();

        // Random operands and handshakes against an arithmetic reference
        for (int n = 0; n < 3000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            drive(ra, rb, rc, rs);
            i_valid = 1'($urandom_range(0, 3) != 0);
            i_ready = 1'($urandom_range(0, 3) != 0);
            #1;
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    chk("rand.unexpected", 32'(o_valid), 32'(1'b0));
                end else begin
                    exp_e = q.pop_front();
                    chk("rand", {6'd0, o_carry,
`ifdef CLA_OVERFLOW_EN
                        o_overflow,
`else
                        exp_e[0],
`endif
                        o_result}, {6'd0, exp_e[W+1], exp_e[0], exp_e[W:1]});
                end
            end
            took = i_valid && o_ready;
            if (took) begin
                bb   = rs ? ~rb : rb;
                full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, (rs | rc)};
                q.push_back({full[W], full[W-1:0],
                             (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1])});
            end
            cyc();
        end

        // Drain with a bounded wait
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            #1;
            if (o_valid) begin
                exp_e = q.pop_front();
                chk("drain", {6'd0, o_carry,
`ifdef CLA_OVERFLOW_EN
                    o_overflow,
`else
                    exp_e[0],
`endif
                    o_result}, {6'd0, exp_e[W+1], exp_e[0], exp_e[W:1]});
            end
            cyc();
        end
        chk("drain.left", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
